// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one unified memory port between fetch and data access.
// One access in flight at a time; data has priority, bounded by a starvation counter.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                IF_REQ,
    input  logic [ADDR_W-1:0]   IF_ADDR,
    output logic [DATA_W-1:0]   IF_RDATA,
    output logic                IF_VALID,
    input  logic                DM_REQ,
    input  logic                DM_WE,
    input  logic [ADDR_W-1:0]   DM_ADDR,
    input  logic [DATA_W-1:0]   DM_WDATA,
    input  logic [DATA_W/8-1:0] DM_BE,
    output logic [DATA_W-1:0]   DM_RDATA,
    output logic                DM_VALID,
    output logic                MEM_REQ,
    output logic                MEM_WE,
    output logic [ADDR_W-1:0]   MEM_ADDR,
    output logic [DATA_W-1:0]   MEM_WDATA,
    output logic [DATA_W/8-1:0] MEM_BE,
    input  logic                MEM_ACK,
    input  logic [DATA_W-1:0]   MEM_RDATA,
    output logic                BUSY
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              mem_req_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [BE_W-1:0]   mem_be_d;
    logic              if_valid_d;
    logic              dm_valid_d;
    logic [DATA_W-1:0] if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_d;
    logic              busy_d;

    logic              starved;
    logic              grant_dm;
    logic              grant_if;

    // Fetch only wins a contested slot once data has had STARVE_MAX turns.
    assign starved  = IF_REQ && (cnt_q == CNT_MAX);
    assign grant_dm = DM_REQ && !starved;
    assign grant_if = IF_REQ && !grant_dm;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = MEM_REQ;
        mem_we_d    = MEM_WE;
        mem_addr_d  = MEM_ADDR;
        mem_wdata_d = MEM_WDATA;
        mem_be_d    = MEM_BE;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        if_rdata_d  = IF_RDATA;
        dm_rdata_d  = DM_RDATA;

        unique case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d     = DM_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = DM_WE;
                    mem_addr_d  = DM_ADDR;
                    mem_wdata_d = DM_WDATA;
                    mem_be_d    = DM_BE;
                    if (IF_REQ && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (grant_if) begin
                    state_d     = IF_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = IF_ADDR;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                    cnt_d       = '0;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (MEM_ACK) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_be_d    = '0;
                    if (state_q == IF_BUSY) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = MEM_RDATA;
                    end else begin
                        dm_valid_d = 1'b1;
                        if (!MEM_WE) begin
                            dm_rdata_d = MEM_RDATA;
                        end
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            MEM_BE    <= '0;
            IF_VALID  <= 1'b0;
            DM_VALID  <= 1'b0;
            IF_RDATA  <= '0;
            DM_RDATA  <= '0;
            BUSY      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            MEM_REQ   <= mem_req_d;
            MEM_WE    <= mem_we_d;
            MEM_ADDR  <= mem_addr_d;
            MEM_WDATA <= mem_wdata_d;
            MEM_BE    <= mem_be_d;
            IF_VALID  <= if_valid_d;
            DM_VALID  <= dm_valid_d;
            IF_RDATA  <= if_rdata_d;
            DM_RDATA  <= dm_rdata_d;
            BUSY      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then random traffic
// against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int SM = 2;

    logic          CLK;
    logic          RSTN;
    logic          IF_REQ;
    logic [AW-1:0] IF_ADDR;
    logic [DW-1:0] IF_RDATA;
    logic          IF_VALID;
    logic          DM_REQ;
    logic          DM_WE;
    logic [AW-1:0] DM_ADDR;
    logic [DW-1:0] DM_WDATA;
    logic [BW-1:0] DM_BE;
    logic [DW-1:0] DM_RDATA;
    logic          DM_VALID;
    logic          MEM_REQ;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [BW-1:0] MEM_BE;
    logic          MEM_ACK;
    logic [DW-1:0] MEM_RDATA;
    logic          BUSY;

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SM)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .IF_REQ    (IF_REQ),
        .IF_ADDR   (IF_ADDR),
        .IF_RDATA  (IF_RDATA),
        .IF_VALID  (IF_VALID),
        .DM_REQ    (DM_REQ),
        .DM_WE     (DM_WE),
        .DM_ADDR   (DM_ADDR),
        .DM_WDATA  (DM_WDATA),
        .DM_BE     (DM_BE),
        .DM_RDATA  (DM_RDATA),
        .DM_VALID  (DM_VALID),
        .MEM_REQ   (MEM_REQ),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_BE    (MEM_BE),
        .MEM_ACK   (MEM_ACK),
        .MEM_RDATA (MEM_RDATA),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Model: owner 0 = none, 1 = fetch, 2 = data
    int            owner;
    int            m_cnt;
    logic          e_mem_req;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [BW-1:0] e_be;
    logic          e_if_valid;
    logic          e_dm_valid;
    logic [DW-1:0] e_if_rdata;
    logic [DW-1:0] e_dm_rdata;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear_port();
        e_mem_req = 1'b0;
        e_we      = 1'b0;
        e_addr    = '0;
        e_wdata   = '0;
        e_be      = '0;
    endtask

    task automatic model_reset();
        owner      = 0;
        m_cnt      = 0;
        model_clear_port();
        e_if_valid = 1'b0;
        e_dm_valid = 1'b0;
        e_if_rdata = '0;
        e_dm_rdata = '0;
    endtask

    task automatic model_tick();
        int pick;
        if (!RSTN) begin
            model_reset();
            return;
        end
        e_if_valid = 1'b0;
        e_dm_valid = 1'b0;
        pick = 0;
        if (owner == 0) begin
            if (DM_REQ && IF_REQ) pick = (m_cnt == SM) ? 1 : 2;
            else if (DM_REQ) pick = 2;
            else if (IF_REQ) pick = 1;
            if (pick == 2) begin
                owner     = 2;
                e_mem_req = 1'b1;
                e_we      = DM_WE;
                e_addr    = DM_ADDR;
                e_wdata   = DM_WDATA;
                e_be      = DM_BE;
                if (IF_REQ && m_cnt < SM) m_cnt++;
            end else if (pick == 1) begin
                owner     = 1;
                e_mem_req = 1'b1;
                e_we      = 1'b0;
                e_addr    = IF_ADDR;
                e_wdata   = '0;
                e_be      = '1;
                m_cnt     = 0;
            end
        end else if (MEM_ACK) begin
            if (owner == 1) begin
                e_if_valid = 1'b1;
                e_if_rdata = MEM_RDATA;
            end else begin
                e_dm_valid = 1'b1;
                if (!e_we) e_dm_rdata = MEM_RDATA;
            end
            owner = 0;
            model_clear_port();
        end
    endtask

    task automatic compare_all();
        chk("mem_req", MEM_REQ, e_mem_req);
        chk("mem_we", MEM_WE, e_we);
        chk("mem_addr", MEM_ADDR, e_addr);
        chk("mem_wdata", MEM_WDATA, e_wdata);
        chk("mem_be", MEM_BE, e_be);
        chk("if_valid", IF_VALID, e_if_valid);
        chk("dm_valid", DM_VALID, e_dm_valid);
        chk("if_rdata", IF_RDATA, e_if_rdata);
        chk("dm_rdata", DM_RDATA, e_dm_rdata);
        chk("busy", BUSY, owner != 0);
        chk("valid_excl", IF_VALID & DM_VALID, 1'b0);
    endtask

    task automatic step();
        @(posedge CLK);
        model_tick();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic idle_inputs();
        IF_REQ    = 1'b0;
        IF_ADDR   = '0;
        DM_REQ    = 1'b0;
        DM_WE     = 1'b0;
        DM_ADDR   = '0;
        DM_WDATA  = '0;
        DM_BE     = '0;
        MEM_ACK   = 1'b0;
        MEM_RDATA = '0;
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        idle_inputs();
        model_reset();
        step();
        RSTN = 1'b1;
    endtask

    int   grants[$];
    logic prev_req;
    logic [DW-1:0] saved;
    logic if_pend;
    logic dm_pend;
    int   ack_wait;

    initial begin
        model_reset();
        idle_inputs();
        RSTN = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 6; i++) begin
            IF_REQ    = 1'($urandom);
            IF_ADDR   = $urandom;
            DM_REQ    = 1'($urandom);
            DM_WE     = 1'($urandom);
            DM_ADDR   = $urandom;
            DM_WDATA  = $urandom;
            DM_BE     = 4'($urandom);
            MEM_ACK   = 1'($urandom);
            MEM_RDATA = $urandom;
            step();
        end
        chk("rst_mem_req", MEM_REQ, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        idle_inputs();
        RSTN = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("rel_mem_addr", MEM_ADDR, '0);

        // Single fetch: ACK on the third edge after the grant edge
        IF_REQ  = 1'b1;
        IF_ADDR = 32'h100;
        step();
        chk("t2_req_c1", MEM_REQ, 1'b1);
        chk("t2_addr_c1", MEM_ADDR, 32'h100);
        step();
        step();
        chk("t2_req_c3", MEM_REQ, 1'b1);
        chk("t2_ifv_c3", IF_VALID, 1'b0);
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'h00500093;
        step();
        chk("t2_ifv_c4", IF_VALID, 1'b1);
        chk("t2_rdata_c4", IF_RDATA, 32'h00500093);
        chk("t2_req_c4", MEM_REQ, 1'b0);
        MEM_ACK = 1'b0;
        IF_REQ  = 1'b0;
        step();
        chk("t2_ifv_c5", IF_VALID, 1'b0);

        // Contention with STARVE_MAX=2
        do_reset();
        IF_REQ  = 1'b1;
        IF_ADDR = 32'h400;
        DM_REQ  = 1'b1;
        DM_ADDR = 32'h800;
        DM_WE   = 1'b0;
        prev_req = 1'b0;
        for (int c = 0; c < 60 && grants.size() < 6; c++) begin
            step();
            if (MEM_REQ && !prev_req) grants.push_back(MEM_ADDR == 32'h800 ? 2 : 1);
            prev_req  = MEM_REQ;
            MEM_ACK   = MEM_REQ;
            MEM_RDATA = $urandom;
        end
        chk("t3_count", grants.size(), 6);
        for (int i = 0; i < 6; i++) begin
            int exp_g;
            exp_g = (i % 3 == 2) ? 1 : 2;
            chk($sformatf("t3_grant%0d", i), i < grants.size() ? grants[i] : 0, exp_g);
        end
        IF_REQ = 1'b0;
        DM_REQ = 1'b0;
        MEM_ACK = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            MEM_ACK = MEM_REQ;
        end
        MEM_ACK = 1'b0;
        step();

        // Load, then store that must not touch DM_RDATA
        DM_REQ  = 1'b1;
        DM_WE   = 1'b0;
        DM_ADDR = 32'h3000;
        step();
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'hCAFEF00D;
        step();
        chk("t4_load_rdata", DM_RDATA, 32'hCAFEF00D);
        saved    = 32'hCAFEF00D;
        MEM_ACK  = 1'b0;
        DM_WE    = 1'b1;
        DM_ADDR  = 32'h2000;
        DM_WDATA = 32'hDEADBEEF;
        DM_BE    = 4'b0011;
        step();
        chk("t4_we", MEM_WE, 1'b1);
        chk("t4_addr", MEM_ADDR, 32'h2000);
        chk("t4_wdata", MEM_WDATA, 32'hDEADBEEF);
        chk("t4_be", MEM_BE, 4'b0011);
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'h12345678;
        step();
        chk("t4_dmv", DM_VALID, 1'b1);
        chk("t4_rdata_hold", DM_RDATA, saved);
        MEM_ACK = 1'b0;
        DM_REQ  = 1'b0;
        DM_WE   = 1'b0;
        step();

        // Reset during a data access, then a late ACK
        DM_REQ  = 1'b1;
        DM_ADDR = 32'h44;
        step();
        step();
        chk("t5_busy_pre", BUSY, 1'b1);
        RSTN = 1'b0;
        #1;
        chk("t5_req_async", MEM_REQ, 1'b0);
        chk("t5_busy_async", BUSY, 1'b0);
        model_reset();
        DM_REQ = 1'b0;
        step();
        RSTN    = 1'b1;
        MEM_ACK = 1'b1;
        step();
        chk("t5_late_dmv", DM_VALID, 1'b0);
        chk("t5_late_ifv", IF_VALID, 1'b0);
        MEM_ACK = 1'b0;
        step();

        // ACK while idle, then fetch whose REQ drops after grant
        MEM_ACK = 1'b1;
        step();
        MEM_ACK = 1'b0;
        step();
        chk("t6_idle_ack", IF_VALID | DM_VALID, 1'b0);
        IF_REQ  = 1'b1;
        IF_ADDR = 32'h200;
        step();
        IF_REQ = 1'b0;
        step();
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'hA5A5A5A5;
        step();
        chk("t6_drop_ifv", IF_VALID, 1'b1);
        MEM_ACK = 1'b0;
        step();

        // Random traffic
        if_pend  = 1'b0;
        dm_pend  = 1'b0;
        ack_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            if (if_pend && IF_VALID) begin
                if_pend = 1'b0;
                IF_REQ  = 1'b0;
            end
            if (dm_pend && DM_VALID) begin
                dm_pend = 1'b0;
                DM_REQ  = 1'b0;
            end
            if (if_pend && owner == 1 && $urandom_range(0, 9) == 0) IF_REQ = 1'b0;
            if (dm_pend && owner == 2 && $urandom_range(0, 9) == 0) DM_REQ = 1'b0;
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1'b1;
                IF_REQ  = 1'b1;
                IF_ADDR = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend  = 1'b1;
                DM_REQ   = 1'b1;
                DM_WE    = 1'($urandom);
                DM_ADDR  = $urandom;
                DM_WDATA = $urandom;
                DM_BE    = 4'($urandom);
            end
            MEM_ACK   = 1'b0;
            MEM_RDATA = $urandom;
            if (MEM_REQ) begin
                if (ack_wait == 0) begin
                    MEM_ACK  = 1'b1;
                    ack_wait = $urandom_range(0, 3);
                end else begin
                    ack_wait--;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                MEM_ACK = 1'b1;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
